// File: rtl/exec_pkg.sv
// Shared types and constants for the execute/writeback stage.
package exec_pkg;

    localparam int DW = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MOV = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WB    = 2'd2
    } state_t;

    // Shifts run serially in the stage; everything else goes through the ALU.
    function automatic logic is_shift_op(input op_t op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/exec_stage_alu_comb.sv
// Single-cycle ALU for the non-shift opcodes; returns {carry, result}.
module alu_comb
    import exec_pkg::*;
(
    input  op_t           op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW:0]   res
);

    logic [DW:0] sum;
    logic [DW:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // Opcode select; SUB carry means "no borrow", i.e. a >= b.
    always_comb begin
        res = {1'b0, a};
        case (op)
            OP_ADD:  res = sum;
            OP_SUB:  res = {~diff[DW], diff[DW-1:0]};
            OP_AND:  res = {1'b0, a & b};
            OP_OR:   res = {1'b0, a | b};
            OP_XOR:  res = {1'b0, a ^ b};
            OP_MOV:  res = {1'b0, b};
            default: res = {1'b0, a};
        endcase
    end

endmodule

// File: rtl/exec_stage.sv
// Execute/writeback stage: one-cycle ALU ops, serial shifts, one write
// strobe per accepted bundle, and architectural zero/carry flags.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for a bundle, in_ready=1, no write
//   ST_SHIFT | serial shift in progress, one bit per cycle, in_ready=0
//   ST_WB    | wr_en=1 for this cycle; may accept the next bundle
module exec_stage
    import exec_pkg::*;
#(
    parameter int pw = 4
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    op,
    input  logic [DW-1:0] datA,
    input  logic [DW-1:0] datB,
    input  logic [pw:0]   dst_addr,
    output logic          wr_en,
    output logic [pw:0]   wr_addr,
    output logic [DW-1:0] dat_out,
    output logic          zero_flag,
    output logic          carry_flag
);

    state_t        state, state_n;
    logic [DW-1:0] acc;
    logic [2:0]    cnt;
    logic          sh_left;
    logic [pw:0]   dst_q;

    logic          accept;
    logic          shift_op;
    logic [2:0]    amt;
    logic [DW:0]   alu_res;
    logic [DW-1:0] acc_sh;
    logic          sh_out;

    logic          wb_load;
    logic          sh_load;
    logic [DW-1:0] res_n;
    logic          cy_n;
    logic [pw:0]   addr_n;

    alu_comb u_alu (
        .op  (op_t'(op)),
        .a   (datA),
        .b   (datB),
        .res (alu_res)
    );

    assign in_ready = (state == ST_IDLE) || (state == ST_WB);
    assign wr_en    = (state == ST_WB);
    assign accept   = in_valid && in_ready;
    assign shift_op = is_shift_op(op_t'(op));
    assign amt      = datB[2:0];

    assign acc_sh = sh_left ? {acc[DW-2:0], 1'b0} : {1'b0, acc[DW-1:1]};
    assign sh_out = sh_left ? acc[DW-1] : acc[0];

    // Next state and the value to be captured on entry to write-back.
    always_comb begin
        state_n = state;
        wb_load = 1'b0;
        sh_load = 1'b0;
        res_n   = alu_res[DW-1:0];
        cy_n    = alu_res[DW];
        addr_n  = dst_addr;
        case (state)
            ST_IDLE, ST_WB: begin
                if (accept) begin
                    if (shift_op && (amt != 3'd0)) begin
                        sh_load = 1'b1;
                        state_n = ST_SHIFT;
                    end else begin
                        wb_load = 1'b1;
                        state_n = ST_WB;
                        if (shift_op) begin
                            res_n = datA;
                            cy_n  = 1'b0;
                        end
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt == 3'd1) begin
                    wb_load = 1'b1;
                    state_n = ST_WB;
                    res_n   = acc_sh;
                    cy_n    = sh_out;
                    addr_n  = dst_q;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Shift accumulator and remaining-bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            sh_left <= 1'b0;
            dst_q   <= '0;
        end else if (sh_load) begin
            acc     <= datA;
            cnt     <= amt;
            sh_left <= (op_t'(op) == OP_SHL);
            dst_q   <= dst_addr;
        end else if (state == ST_SHIFT) begin
            acc <= acc_sh;
            cnt <= cnt - 3'd1;
        end
    end

    // Write port and flags; captured on WB entry, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_out    <= '0;
            wr_addr    <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
        end else if (wb_load) begin
            dat_out    <= res_n;
            wr_addr    <= addr_n;
            zero_flag  <= (res_n == '0);
            carry_flag <= cy_n;
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage with a behavioural register file on the
// write port.
module tb_exec_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] datA;
    logic [7:0] datB;
    logic [4:0] dst_addr;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] dat_out;
    logic       zero_flag;
    logic       carry_flag;

    int checks = 0;
    int errors = 0;
    int pulses;

    logic [7:0] rf [32];

    exec_stage #(.pw(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .datA       (datA),
        .datB       (datB),
        .dst_addr   (dst_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .dat_out    (dat_out),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (wr_en) rf[wr_addr] <= dat_out;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [4:0] d);
        in_valid = 1'b1;
        op       = o;
        datA     = a;
        datB     = b;
        dst_addr = d;
    endtask

    task automatic wb_chk(input string tag, input logic [4:0] addr, input logic [7:0] dat,
                          input logic z, input logic c);
        chk({tag, "_wr_en"}, {15'd0, wr_en}, 16'd1);
        chk({tag, "_addr"}, {11'd0, wr_addr}, {11'd0, addr});
        chk({tag, "_dat"}, {8'd0, dat_out}, {8'd0, dat});
        chk({tag, "_zero"}, {15'd0, zero_flag}, {15'd0, z});
        chk({tag, "_carry"}, {15'd0, carry_flag}, {15'd0, c});
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        op = 3'd0; datA = 8'h00; datB = 8'h00; dst_addr = 5'd0;
        repeat (2) @(negedge clk);
        chk("rst_wr_en", {15'd0, wr_en}, 16'd0);
        chk("rst_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_dat", {8'd0, dat_out}, 16'h0000);
        chk("rst_flags", {14'd0, zero_flag, carry_flag}, 16'd0);
        rst_n = 1'b1;

        // ADD overflow
        @(negedge clk); drive(3'd0, 8'hF0, 8'h20, 5'h03);
        @(negedge clk); in_valid = 1'b0;
        wb_chk("add", 5'h03, 8'h10, 1'b0, 1'b1);
        @(negedge clk);
        chk("add_one_pulse", {15'd0, wr_en}, 16'd0);
        chk("add_hold_dat", {8'd0, dat_out}, 16'h0010);
        chk("add_rf", {8'd0, rf[3]}, 16'h0010);

        // SUB equal operands
        drive(3'd1, 8'h55, 8'h55, 5'h04);
        @(negedge clk); in_valid = 1'b0;
        wb_chk("sub_eq", 5'h04, 8'h00, 1'b1, 1'b1);

        // SUB with borrow
        @(negedge clk); drive(3'd1, 8'h10, 8'h20, 5'h05);
        @(negedge clk); in_valid = 1'b0;
        wb_chk("sub_borrow", 5'h05, 8'hF0, 1'b0, 1'b0);

        // SHL by 3
        @(negedge clk); drive(3'd5, 8'h81, 8'h03, 5'h06);
        @(negedge clk); in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("shl_busy_ready", {15'd0, in_ready}, 16'd0);
            chk("shl_busy_wr_en", {15'd0, wr_en}, 16'd0);
            if (i < 2) @(negedge clk);
        end
        @(negedge clk);
        wb_chk("shl3", 5'h06, 8'h08, 1'b0, 1'b0);
        @(negedge clk);
        chk("shl3_one_pulse", {15'd0, wr_en}, 16'd0);

        // SHR by 1
        drive(3'd6, 8'h81, 8'h01, 5'h07);
        @(negedge clk); in_valid = 1'b0;
        chk("shr_busy_ready", {15'd0, in_ready}, 16'd0);
        @(negedge clk);
        wb_chk("shr1", 5'h07, 8'h40, 1'b0, 1'b1);

        // SHL by 0 behaves as a single-cycle op
        @(negedge clk); drive(3'd5, 8'hAA, 8'h00, 5'h08);
        @(negedge clk); in_valid = 1'b0;
        wb_chk("shl0", 5'h08, 8'hAA, 1'b0, 1'b0);

        // Destination 0 is an ordinary register
        @(negedge clk); drive(3'd0, 8'h01, 8'hFF, 5'h00);
        @(negedge clk); in_valid = 1'b0;
        wb_chk("add_r0", 5'h00, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        chk("r0_rf", {8'd0, rf[0]}, 16'h0000);

        // Back-to-back XOR, OR, MOV
        drive(3'd4, 8'hAA, 8'hFF, 5'h01);
        @(negedge clk);
        wb_chk("b2b_xor", 5'h01, 8'h55, 1'b0, 1'b0);
        chk("b2b_ready0", {15'd0, in_ready}, 16'd1);
        drive(3'd3, 8'h0F, 8'hF0, 5'h02);
        @(negedge clk);
        wb_chk("b2b_or", 5'h02, 8'hFF, 1'b0, 1'b0);
        chk("b2b_ready1", {15'd0, in_ready}, 16'd1);
        drive(3'd7, 8'h00, 8'h7E, 5'h03);
        @(negedge clk); in_valid = 1'b0;
        wb_chk("b2b_mov", 5'h03, 8'h7E, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_end_wr_en", {15'd0, wr_en}, 16'd0);
        chk("b2b_rf1", {8'd0, rf[1]}, 16'h0055);
        chk("b2b_rf2", {8'd0, rf[2]}, 16'h00FF);
        chk("b2b_rf3", {8'd0, rf[3]}, 16'h007E);

        // Reset in the middle of a long shift
        drive(3'd5, 8'hAA, 8'h05, 5'h09);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        chk("mid_shift_ready", {15'd0, in_ready}, 16'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_ready", {15'd0, in_ready}, 16'd1);
        chk("arst_wr_en", {15'd0, wr_en}, 16'd0);
        chk("arst_addr", {11'd0, wr_addr}, 16'd0);
        chk("arst_dat", {8'd0, dat_out}, 16'd0);
        chk("arst_flags", {14'd0, zero_flag, carry_flag}, 16'd0);
        @(negedge clk); rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wr_en) pulses++;
        end
        chk("arst_no_write", pulses[15:0], 16'd0);
        chk("arst_idle_ready", {15'd0, in_ready}, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_stage.md
# exec_stage

Execute/writeback stage between the register file's read ports and its write port. It accepts two 8-bit operands (datA/datB) plus an opcode and destination address, and computes the result in one cycle for logic/arithmetic ops or serially for shifts. It then drives the register file's write interface (dat_in/wr_addr/wr_en) for exactly one cycle per accepted operation. It also keeps architectural zero/carry flags for the downstream branch logic.

## Interface
- pw, 4, register pointer width; addresses are [pw:0] (32 registers), matching reg_file
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand bundle valid
- in_ready  output  1  stage can accept a bundle this cycle
- op  input  3  opcode (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SHL=5, SHR=6, MOV=7)
- datA  input  8  operand A (reg_file datA_out)
- datB  input  8  operand B (reg_file datB_out); shifts use datB[2:0] as amount
- dst_addr  input  pw+1  destination register
- wr_en  output  1  write strobe to reg_file
- wr_addr  output  pw+1  write address to reg_file
- dat_out  output  8  write data to reg_file dat_in
- zero_flag  output  1  last written result == 0
- carry_flag  output  1  carry/borrow/shift-out of last written op

## Operation
- Handshake: transfer when in_valid && in_ready at a rising edge; in_ready = (state==IDLE) || (state==WB).
- FSM states are IDLE, SHIFT, and WB.
  - IDLE: on transfer of a non-shift op, or of a shift with amount 0, register the result and go to WB. On transfer of a shift with amount >0, load the accumulator and counter=amount, then go to SHIFT.
  - SHIFT: each cycle shift the accumulator 1 bit (zero fill) and decrement the counter. When the counter reaches 1 on a cycle, go to WB after that shift. in_valid is ignored in this state.
  - WB: wr_en=1 for this cycle only. A transfer in WB behaves as in IDLE, giving back-to-back writes. With no transfer, go to IDLE.
- Arithmetic is 8-bit modulo 256.
  - ADD: carry = bit 8 of A+B.
  - SUB: result A−B; carry = 1 when A>=B (no borrow).
  - AND, OR, XOR, MOV (result=B): carry = 0.
  - SHL/SHR: carry = last bit shifted out; amount 0 gives result A and carry 0.
- Flags update at the same edge that enters WB and hold otherwise. zero_flag = (result==0).
- wr_addr and dat_out are registered with the result and held stable until the next WB entry.
- dst_addr 0 is not special; it is written like any other register.

## Timing
- Reset (async, any state, including mid-shift): state=IDLE, wr_en=0, wr_addr=0, dat_out=0, zero_flag=0, carry_flag=0, in_ready=1. A bundle in flight is discarded and no write is issued.
- Single-cycle op accepted at edge N: wr_en high from after edge N until edge N+1. reg_file commits at edge N+1, giving a 1-cycle latency.
- Shift by k (1..7) accepted at edge N: SHIFT occupies cycles N..N+k−1 and wr_en is high during the cycle after edge N+k, giving latency k+1.
- Throughput is one single-cycle op per clock when in_valid is held high (WB→WB).
- in_ready is combinational from state only; it never depends on in_valid.

## Structure
- Shared package exec_pkg holds:
  - the op_t enum (3-bit codes above)
  - the state_t enum (IDLE, SHIFT, WB)
  - localparam DW=8
- One sub-module, alu_comb: purely combinational, takes op, A, and B, and returns {carry, result} for the non-shift ops.
- exec_stage holds the FSM, the shift accumulator/counter, the output registers and the flags.

## Test plan
- Reset during operation: assert rst_n=0 mid-SHIFT -> all outputs zero, in_ready=1 immediately and no wr_en pulse afterwards.
- ADD overflow: A=8'hF0, B=8'h20, dst=5'h03 -> one cycle later wr_en=1, wr_addr=03, dat_out=10, carry=1, zero=0. Reading reg 03 through reg_file then returns 10.
- SUB equal: A=8'h55, B=8'h55 -> dat_out=00, zero=1, carry=1.
- Serial shift: SHL, A=8'h81, B=8'h03 -> in_ready=0 for 3 cycles, then wr_en for 1 cycle with dat_out=08 and carry=0. SHR with A=8'h81, B=8'h01 -> dat_out=40, carry=1.
- Zero shift: SHL amount 0, A=8'hAA -> WB one cycle after accept, dat_out=AA, carry=0.
- Back-to-back: XOR(AA,FF)->r1, then OR(0F,F0)->r2, then MOV(B=7E)->r3 on consecutive cycles -> three consecutive wr_en cycles writing 55, FF, 7E to r1, r2, r3, with in_ready held 1.
